pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central hazard/interlock controller for the 5-stage pipeline.
- Produces the per-stage-register stall vector `stall_C[3:0]`, flush vector `flush_C[3:0]` and the delay-slot annul strobe `slot_flush`, which the IF/ID, ID/EX and EX/MEM registers and the PC register consume.
- Resolves three hazard classes:
  - load-use data hazards;
  - multi-cycle mul/div HI/LO interlocks;
  - exception redirection.
- Also annuls branch-likely delay slots.

Parameters:
- MD_LATENCY, 4, execute cycles of the mul/div unit after issue (legal range 2..15).
- EXC_DRAIN, 1, extra cycles of IF/ID flush after an exception request cycle (0..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- id_md_start  in  1  ID instruction is mult/div
- id_md_use  in  1  ID instruction reads HI/LO (mfhi/mflo)
- br_valid_id  in  1  ID holds a resolved branch
- br_likely_id  in  1  that branch is branch-likely
- br_taken_id  in  1  branch condition true
- exc_req  in  1  exception raised in MEM (single-cycle pulse)
- stall_C  out  4  hold enable: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM
- flush_C  out  4  bubble-insert, same bit mapping
- slot_flush  out  1  annul the delay slot being loaded into IF/ID
- ctrl_busy  out  1  FSM not in IDLE

Behaviour:
- Outputs are combinational from registered state plus current inputs. State, counters and any `PIPE_CTRL_PERF_EN` counters update on posedge clk.
- Reset (`rst`=0, asynchronous): state=IDLE, md_cnt=0, drain_cnt=0, perf counters cleared. While `rst` is low all outputs are 0.
- Consumer priority is fixed at each stage register: flush > stall > slot_flush. This block must never emit stall and flush on the same bit.
- States:
  - IDLE: no interlock active.
  - MD_BUSY: md_cnt > 0.
  - EXC_DRAIN: drain_cnt > 0.
- Hazard terms:
  - lu = ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))
  - md_hz = state==MD_BUSY & (id_md_use | id_md_start)
- Output decode, highest priority first:
  1. exc_req=1 → `flush_C`=4'b1110, `stall_C`=0, `slot_flush`=0. Next state EXC_DRAIN with drain_cnt=EXC_DRAIN, or IDLE if EXC_DRAIN=0. A pending MD_BUSY is abandoned and md_cnt is cleared.
  2. state==EXC_DRAIN → `flush_C`=4'b0010, other outputs 0. drain_cnt decrements; the state goes to IDLE when drain_cnt reaches 1.
  3. lu | md_hz → `stall_C`=4'b0011, `flush_C`=4'b0100, `slot_flush`=0.
  4. Otherwise `stall_C`=0 and `flush_C`=0.
     - `slot_flush` = br_valid_id & br_likely_id & ~br_taken_id.
     - If id_md_start: md_cnt ← MD_LATENCY-1, state ← MD_BUSY. A new mult accepted while IDLE issues without stall.
- md_cnt decrements every cycle in MD_BUSY, including stall cycles. At md_cnt==1 the next state is IDLE, so a stalled mfhi issues the cycle after.
- Stall cycles do not accept id_md_start. The stalled instruction is re-evaluated next cycle.
- Simultaneous lu and md_hz: a single stall. The stall persists until both clear.
- br_valid_id during a stall: no `slot_flush`. The branch stays in ID and is re-evaluated.
- `ctrl_busy` = state≠IDLE.

Optional Feature:
- Macro: `PIPE_CTRL_PERF_EN`.
- Defined:
  - adds outputs perf_lu_cnt[31:0], perf_md_cnt[31:0] and perf_flush_cnt[31:0], all wrapping at 2^32;
  - perf_lu_cnt increments on cycles with lu-caused stall;
  - perf_md_cnt increments on cycles with md_hz-caused stall (both increment if both hazards are present);
  - perf_flush_cnt increments on exc_req cycles.
- Undefined: those ports and registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared definitions header: stage bit indices (PC, IFID, IDEX, EXMEM), state encodings IDLE/MD_BUSY/EXC_DRAIN, and constant 4'b0011 / 4'b0100 stall/bubble patterns.
- One sub-module, pipe_md_tracker: holds the md_cnt countdown and produces busy. Everything else lives in the top.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_uses_rs=1, id_rs=8 → one cycle of `stall_C`=0011, `flush_C`=0100. ex_rd=0 with the same stimulus → no stall.
- MD interlock: id_md_start at cycle 0 with MD_LATENCY=4, mfhi in ID at cycle 1 → stall cycles 1–2, then no stall at cycle 3, and `ctrl_busy` clears at cycle 3.
- Branch-likely not taken: br_valid/likely=1, taken=0 → `slot_flush`=1 for that cycle. Same stimulus with a concurrent lu → `slot_flush`=0 and a stall.
- Exception during MD_BUSY with EXC_DRAIN=1 → `flush_C`=1110, then 0010 for one cycle, then IDLE with md_cnt=0 and no stall on a following mfhi.
- Reset asserted mid-MD_BUSY → all outputs 0 immediately (asynchronous). After release the state is IDLE and a new mfhi issues without stall.
- With `PIPE_CTRL_PERF_EN` defined: 3 load-use stalls + 1 exception → perf_lu_cnt=3, perf_flush_cnt=1, perf_md_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: stage bit indices,
// FSM state encoding and the fixed stall/flush patterns.
package pipe_hazard_ctrl_pkg;

  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MD_BUSY   = 2'd1,
    ST_EXC_DRAIN = 2'd2
  } hz_state_e;

  // Hold PC and IF/ID, bubble into ID/EX.
  localparam logic [3:0] STALL_PAT  = 4'b0011;
  localparam logic [3:0] BUBBLE_PAT = 4'b0100;
  // Exception squashes everything younger than MEM; drain keeps flushing IF/ID.
  localparam logic [3:0] EXC_FLUSH_PAT = (4'b1 << STG_IFID) | (4'b1 << STG_IDEX) |
                                         (4'b1 << STG_EXMEM);
  localparam logic [3:0] DRAIN_FLUSH_PAT = 4'b1 << STG_IFID;

endpackage

// File: rtl/pipe_md_tracker.sv
// Mul/div HI/LO interlock countdown; busy while the result is not yet forwardable.
module pipe_md_tracker
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic busy,
  output logic busy_nxt
);

  localparam logic [3:0] LOAD_VAL = 4'(MD_LATENCY - 1);

  logic [3:0] md_cnt_q, md_cnt_d;

  // The count reaching 1 ends the interlock: HI/LO is forwardable in the last execute cycle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (clear) begin
      md_cnt_d = '0;
    end else if (start) begin
      md_cnt_d = LOAD_VAL;
    end else if (md_cnt_q > 4'd2) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else begin
      md_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy     = (md_cnt_q != 4'd0);
  assign busy_nxt = (md_cnt_d != 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/interlock controller: load-use, mul/div HI/LO, exception flush
// and branch-likely slot annul. Optional perf counters under `PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int EXC_DRAIN  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_md_start,
  input  logic       id_md_use,
  input  logic       br_valid_id,
  input  logic       br_likely_id,
  input  logic       br_taken_id,
  input  logic       exc_req,
  output logic [3:0] stall_C,
  output logic [3:0] flush_C,
  output logic       slot_flush,
  output logic       ctrl_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_md_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [1:0] DRAIN_LOAD = 2'(EXC_DRAIN);

  hz_state_e  state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       lu, md_hz, md_busy, md_busy_nxt;
  logic       md_start_acc;
  logic [3:0] stall_raw, flush_raw;
  logic       slot_raw;

  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign md_hz = md_busy && (id_md_use || id_md_start);

  pipe_md_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_tracker (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start_acc),
    .clear   (exc_req),
    .busy    (md_busy),
    .busy_nxt(md_busy_nxt)
  );

  always_comb begin
    stall_raw    = '0;
    flush_raw    = '0;
    slot_raw     = 1'b0;
    md_start_acc = 1'b0;
    if (exc_req) begin
      flush_raw = EXC_FLUSH_PAT;
    end else if (state_q == ST_EXC_DRAIN) begin
      flush_raw = DRAIN_FLUSH_PAT;
    end else if (lu || md_hz) begin
      stall_raw = STALL_PAT;
      flush_raw = BUBBLE_PAT;
    end else begin
      slot_raw     = br_valid_id && br_likely_id && !br_taken_id;
      md_start_acc = id_md_start;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (exc_req) begin
      drain_cnt_d = DRAIN_LOAD;
      state_d     = (DRAIN_LOAD != 2'd0) ? ST_EXC_DRAIN : ST_IDLE;
    end else if (state_q == ST_EXC_DRAIN) begin
      drain_cnt_d = drain_cnt_q - 2'd1;
      state_d     = (drain_cnt_q <= 2'd1) ? ST_IDLE : ST_EXC_DRAIN;
    end else begin
      state_d = md_busy_nxt ? ST_MD_BUSY : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after an edge.
  assign stall_C    = rst ? stall_raw : 4'b0000;
  assign flush_C    = rst ? flush_raw : 4'b0000;
  assign slot_flush = rst ? slot_raw  : 1'b0;
  assign ctrl_busy  = rst ? (state_q != ST_IDLE) : 1'b0;

`ifdef PIPE_CTRL_PERF_EN
  logic        hz_window;
  logic [31:0] perf_lu_cnt_q, perf_lu_cnt_d;
  logic [31:0] perf_md_cnt_q, perf_md_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  assign hz_window = !exc_req && (state_q != ST_EXC_DRAIN);

  always_comb begin
    perf_lu_cnt_d    = perf_lu_cnt_q + {31'd0, hz_window && lu};
    perf_md_cnt_d    = perf_md_cnt_q + {31'd0, hz_window && md_hz};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, exc_req};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_cnt_q    <= '0;
      perf_md_cnt_q    <= '0;
      perf_flush_cnt_q <= '0;
    end else begin
      perf_lu_cnt_q    <= perf_lu_cnt_d;
      perf_md_cnt_q    <= perf_md_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_lu_cnt    = perf_lu_cnt_q;
  assign perf_md_cnt    = perf_md_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (MD_LATENCY=4, EXC_DRAIN=1).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       id_md_start, id_md_use;
  logic       br_valid_id, br_likely_id, br_taken_id, exc_req;
  logic [3:0] stall_C, flush_C;
  logic       slot_flush, ctrl_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_lu_cnt, perf_md_cnt, perf_flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MD_LATENCY(4),
    .EXC_DRAIN (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_md_start (id_md_start),
    .id_md_use   (id_md_use),
    .br_valid_id (br_valid_id),
    .br_likely_id(br_likely_id),
    .br_taken_id (br_taken_id),
    .exc_req     (exc_req),
    .stall_C     (stall_C),
    .flush_C     (flush_C),
    .slot_flush  (slot_flush),
    .ctrl_busy   (ctrl_busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_lu_cnt   (perf_lu_cnt),
    .perf_md_cnt   (perf_md_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] rd;
    logic       mds, mdu, bv, bl, bt, exc;
    logic [3:0] e_stall, e_flush;
    logic       e_slot, e_busy;
  } vec_t;

  vec_t vt[26];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic mr,
                              input logic [4:0] rd, input logic mds, input logic mdu,
                              input logic bv, input logic bl, input logic bt,
                              input logic exc, input logic [3:0] es, input logic [3:0] ef,
                              input logic eslot, input logic ebusy);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.rd = rd;
    v.mds = mds; v.mdu = mdu; v.bv = bv; v.bl = bl; v.bt = bt; v.exc = exc;
    v.e_stall = es; v.e_flush = ef; v.e_slot = eslot; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_mem_read = v.mr; ex_rd = v.rd; id_md_start = v.mds; id_md_use = v.mdu;
    br_valid_id = v.bv; br_likely_id = v.bl; br_taken_id = v.bt; exc_req = v.exc;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] es, input logic [3:0] ef,
                         input logic eslot, input logic ebusy);
    chk4({tag, ".stall"}, stall_C, es);
    chk4({tag, ".flush"}, flush_C, ef);
    chk1({tag, ".slot"}, slot_flush, eslot);
    chk1({tag, ".busy"}, ctrl_busy, ebusy);
  endtask

  // Apply one vector just after a rising edge and sample mid-cycle.
  task automatic step(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    drive(v);
    #3;
    chk_all(tag, v.e_stall, v.e_flush, v.e_slot, v.e_busy);
  endtask

  vec_t z, lu8, mfhi, mstart, ex1;

  initial begin
    //           rs rt urs urt mr rd mds mdu bv bl bt exc  stall    flush    slot busy
    z      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    lu8    = mk(8, 0, 1, 0, 1, 8, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0);
    mfhi   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    mstart = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    ex1    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b1110, 0, 0);

    vt[0]  = z;
    vt[1]  = lu8;
    vt[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    vt[3]  = mk(5, 5, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0);
    vt[4]  = mk(5, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 1, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0);
    vt[7]  = mk(8, 0, 1, 0, 1, 8, 0, 0, 1, 1, 0, 0, 4'b0011, 4'b0100, 0, 0);
    vt[8]  = mstart;
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 1);
    vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 1);
    vt[11] = mfhi;
    vt[12] = mstart;
    vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0000, 4'b1110, 0, 1);
    vt[15] = mk(8, 0, 1, 0, 1, 8, 0, 1, 1, 1, 0, 0, 4'b0000, 4'b0010, 0, 1);
    vt[16] = mfhi;
    vt[17] = mk(8, 0, 1, 0, 1, 8, 1, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 0);
    vt[18] = mfhi;
    vt[19] = mstart;
    vt[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0011, 4'b0100, 0, 1);
    vt[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 1);
    vt[22] = z;
    vt[23] = ex1;
    vt[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0010, 0, 1);
    vt[25] = z;

    // Reset held with hazard-provoking inputs: every output must stay quiet.
    rst = 1'b0;
    drive(lu8);
    exc_req = 1'b1;
    #1;
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    drive(z);
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      step(vt[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of an MD interlock.
    step(mstart, "ar.start");
    step(vt[9], "ar.stall");
    #2;
    drive(lu8);
    id_md_use = 1'b1;
    rst = 1'b0;
    #1;
    chk_all("ar.async", 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    drive(z);
    rst = 1'b1;
    step(mfhi, "ar.mfhi");

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(lu8, "pf.lu0");
    step(lu8, "pf.lu1");
    step(lu8, "pf.lu2");
    step(ex1, "pf.exc");
    step(vt[24], "pf.drain");
    step(z, "pf.idle");
    chk4("perf_lu_lo", perf_lu_cnt[3:0], 4'd3);
    chk1("perf_lu_hi0", (perf_lu_cnt[31:4] == 28'd0), 1'b1);
    chk4("perf_flush_lo", perf_flush_cnt[3:0], 4'd1);
    chk1("perf_flush_hi0", (perf_flush_cnt[31:4] == 28'd0), 1'b1);
    chk1("perf_md_zero", (perf_md_cnt == 32'd0), 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
